// File: rtl/bp_pkg.sv
// Shared constants and helpers for the branch predictor.
//   MODE_*       : predictor mode selectors
//   XLEN         : PC / target width
//   ctr_init_val : weakly-not-taken reset value for a CTR_BITS counter
package bp_pkg;

  localparam int unsigned MODE_STATIC  = 0;
  localparam int unsigned MODE_BIMODAL = 1;
  localparam int unsigned MODE_GSHARE  = 2;

  localparam int unsigned XLEN = 32;

  // Largest value whose MSB is clear, i.e. 2^(bits-1)-1.
  function automatic int unsigned ctr_init_val(input int unsigned ctr_bits);
    return (32'd1 << (ctr_bits - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Up/down saturating counter.
//   clk, rst : clock, asynchronous active-high reset (loads INIT)
//   en       : apply one step this cycle
//   inc      : 1 = count up (sticks at all-ones), 0 = count down (sticks at 0)
//   count    : registered counter value
module bp_sat_counter #(
  parameter int unsigned       WIDTH = 2,
  parameter logic [WIDTH-1:0]  INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= INIT;
    end else if (en) begin
      if (inc) begin
        if (count != {WIDTH{1'b1}}) count <= count + WIDTH'(1);
      end else begin
        if (count != '0) count <= count - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Branch predictor: flop-based BTB plus per-entry saturating counters,
// static / bimodal / gshare indexing, and resolved-branch statistics.
//   lookup_valid, lookup_pc       : fetch-side query
//   pred_taken, pred_target       : combinational prediction for the query
//   update_*                      : execute-side resolution of one instruction
//   stat_clr                      : synchronous clear of the statistics
//   stat_branches, stat_mispredicts : saturating 32-bit counters (registered)
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned TAG_BITS = 8,
  parameter int unsigned GHR_BITS = 6,
  parameter int unsigned MODE     = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lookup_valid,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_is_branch,
  input  logic            update_taken,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_mispredict,
  input  logic            stat_clr,
  output logic [XLEN-1:0] stat_branches,
  output logic [XLEN-1:0] stat_mispredicts
);

  localparam int unsigned       IW         = $clog2(ENTRIES);
  localparam int unsigned       TAG_LO     = IW + 1;
  localparam int unsigned       TAG_HI     = IW + TAG_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init_val(CTR_BITS));
  localparam bit                TABLES_ON  = (MODE != MODE_STATIC);
  localparam bit                USE_GHR    = (MODE == MODE_GSHARE);

  logic [ENTRIES-1:0]               valid_q;
  logic [TAG_BITS-1:0]              tag_q    [ENTRIES];
  logic [XLEN-1:0]                  target_q [ENTRIES];
  logic [ENTRIES-1:0][CTR_BITS-1:0] ctr;
  logic [GHR_BITS-1:0]              ghr_q;
  logic [XLEN-1:0]                  stat_br_q;
  logic [XLEN-1:0]                  stat_mp_q;

  logic [IW-1:0]       lk_idx;
  logic [IW-1:0]       up_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic [TAG_BITS-1:0] up_tag;
  logic                hit_c;
  logic                upd_c;
  logic                tbl_upd_c;

  // Table index; gshare folds the history into the low index bits.
  function automatic logic [IW-1:0] pc_index(input logic [XLEN-1:0] pc,
                                             input logic [GHR_BITS-1:0] ghr);
    logic [IW-1:0] idx;
    idx = pc[IW:1];
    if (USE_GHR) idx = idx ^ IW'(ghr);
    return idx;
  endfunction

  assign lk_idx = pc_index(lookup_pc, ghr_q);
  assign up_idx = pc_index(update_pc, ghr_q);   // pre-shift history
  assign lk_tag = lookup_pc[TAG_HI:TAG_LO];
  assign up_tag = update_pc[TAG_HI:TAG_LO];

  assign upd_c     = update_valid && update_is_branch;
  assign tbl_upd_c = upd_c && TABLES_ON;

  // Lookup reads current state only; a same-cycle update shows up next cycle.
  assign hit_c       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = lookup_valid && hit_c && ctr[lk_idx][CTR_BITS-1] && TABLES_ON;
  assign pred_target = pred_taken ? target_q[lk_idx] : '0;

  // Direction counters, one per entry.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    bp_sat_counter #(
      .WIDTH (CTR_BITS),
      .INIT  (CTR_INIT)
    ) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .en    (tbl_upd_c && (up_idx == IW'(i))),
      .inc   (update_taken),
      .count (ctr[i])
    );
  end

  // BTB: only taken branches allocate or refresh an entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (tbl_upd_c && update_taken) begin
      valid_q[up_idx]  <= 1'b1;
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= update_target;
    end
  end

  // Global history, shifted at resolution time (non-speculative).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (tbl_upd_c) begin
      ghr_q <= GHR_BITS'({ghr_q, update_taken});
    end
  end

  // Statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else if (stat_clr) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else if (upd_c) begin
      if (stat_br_q != {XLEN{1'b1}}) stat_br_q <= stat_br_q + XLEN'(1);
      if (update_mispredict && (stat_mp_q != {XLEN{1'b1}})) stat_mp_q <= stat_mp_q + XLEN'(1);
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;

  // PC bits outside index/tag do not participate.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[XLEN-1:TAG_HI+1], lookup_pc[0],
                            update_pc[XLEN-1:TAG_HI+1], update_pc[0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: three instances (static, bimodal, gshare) share
// one stimulus stream and are checked every cycle against a table model.
module tb_branch_predictor;

  localparam int unsigned E  = 16;
  localparam int unsigned CB = 2;
  localparam int unsigned TB = 4;
  localparam int unsigned GB = 3;
  localparam int unsigned IW = 4;
  localparam int unsigned CMAX  = (1 << CB) - 1;
  localparam int unsigned CINIT = (1 << (CB - 1)) - 1;

  logic        clk;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_is_branch;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_mispredict;
  logic        stat_clr;

  logic        pt  [3];
  logic [31:0] ptg [3];
  logic [31:0] sb  [3];
  logic [31:0] sm  [3];

  int cmp_count = 0;
  int err_count = 0;

  branch_predictor #(.ENTRIES(E), .CTR_BITS(CB), .TAG_BITS(TB), .GHR_BITS(GB), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_taken(pt[0]), .pred_target(ptg[0]), .update_valid(update_valid),
    .update_pc(update_pc), .update_is_branch(update_is_branch), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .stat_clr(stat_clr), .stat_branches(sb[0]), .stat_mispredicts(sm[0]));

  branch_predictor #(.ENTRIES(E), .CTR_BITS(CB), .TAG_BITS(TB), .GHR_BITS(GB), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_taken(pt[1]), .pred_target(ptg[1]), .update_valid(update_valid),
    .update_pc(update_pc), .update_is_branch(update_is_branch), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .stat_clr(stat_clr), .stat_branches(sb[1]), .stat_mispredicts(sm[1]));

  branch_predictor #(.ENTRIES(E), .CTR_BITS(CB), .TAG_BITS(TB), .GHR_BITS(GB), .MODE(2)) dut2 (
    .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_taken(pt[2]), .pred_target(ptg[2]), .update_valid(update_valid),
    .update_pc(update_pc), .update_is_branch(update_is_branch), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .stat_clr(stat_clr), .stat_branches(sb[2]), .stat_mispredicts(sm[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  bit          m_valid [3][E];
  int unsigned m_tag   [3][E];
  logic [31:0] m_tgt   [3][E];
  int unsigned m_ctr   [3][E];
  int unsigned m_ghr   [3];
  logic [31:0] m_sb    [3];
  logic [31:0] m_sm    [3];

  function automatic int unsigned m_index(int m, logic [31:0] pc);
    int unsigned idx;
    idx = (pc >> 1) % E;
    if (m == 2) idx = idx ^ m_ghr[m];
    return idx;
  endfunction

  function automatic int unsigned m_tagof(logic [31:0] pc);
    return (pc >> (IW + 1)) % (1 << TB);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < int'(E); i++) begin
        m_valid[m][i] = 1'b0;
        m_tag[m][i]   = 0;
        m_tgt[m][i]   = '0;
        m_ctr[m][i]   = CINIT;
      end
      m_ghr[m] = 0;
      m_sb[m]  = '0;
      m_sm[m]  = '0;
    end
  endtask

  task automatic model_step();
    bit upd;
    int unsigned idx;
    upd = update_valid && update_is_branch;
    for (int m = 0; m < 3; m++) begin
      if (stat_clr) begin
        m_sb[m] = '0;
        m_sm[m] = '0;
      end else if (upd) begin
        if (m_sb[m] != 32'hFFFF_FFFF) m_sb[m] = m_sb[m] + 32'd1;
        if (update_mispredict && m_sm[m] != 32'hFFFF_FFFF) m_sm[m] = m_sm[m] + 32'd1;
      end
      if (upd && m != 0) begin
        idx = m_index(m, update_pc);
        if (update_taken) begin
          if (m_ctr[m][idx] < CMAX) m_ctr[m][idx]++;
          m_valid[m][idx] = 1'b1;
          m_tag[m][idx]   = m_tagof(update_pc);
          m_tgt[m][idx]   = update_target;
        end else if (m_ctr[m][idx] > 0) begin
          m_ctr[m][idx]--;
        end
        m_ghr[m] = ((m_ghr[m] << 1) | (update_taken ? 1 : 0)) % (1 << GB);
      end
    end
  endtask

  // Compare every DUT against the model, then advance the model to the
  // state the DUTs will hold after the coming rising edge.
  always @(negedge clk) begin
    bit          e_t;
    logic [31:0] e_tgt;
    int unsigned idx;
    if (rst) model_reset();
    for (int m = 0; m < 3; m++) begin
      idx   = m_index(m, lookup_pc);
      e_t   = (m != 0) && lookup_valid && m_valid[m][idx] &&
              (m_tag[m][idx] == m_tagof(lookup_pc)) && (m_ctr[m][idx] > CINIT);
      e_tgt = e_t ? m_tgt[m][idx] : 32'h0;
      chk($sformatf("mode%0d pred_taken", m), 32'(pt[m]), 32'(e_t));
      chk($sformatf("mode%0d pred_target", m), ptg[m], e_tgt);
      chk($sformatf("mode%0d stat_branches", m), sb[m], m_sb[m]);
      chk($sformatf("mode%0d stat_mispredicts", m), sm[m], m_sm[m]);
    end
    if (!rst) model_step();
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_update(logic v, logic [31:0] pc, logic tk, logic [31:0] tgt, logic mis);
    update_valid      = v;
    update_is_branch  = v;
    update_pc         = pc;
    update_taken      = tk;
    update_target     = tgt;
    update_mispredict = mis;
  endtask

  initial begin
    rst = 1'b1;
    lookup_valid = 1'b0;
    lookup_pc    = '0;
    stat_clr     = 1'b0;
    set_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Fresh state: no prediction.
    lookup_valid = 1'b1;
    lookup_pc    = 32'h100;
    @(negedge clk);
    chk("lit reset pred_taken", 32'(pt[1]), 32'h0);
    chk("lit reset pred_target", ptg[1], 32'h0);
    chk("lit reset stat_branches", sb[1], 32'h0);
    step();

    // Two taken updates train 0x100 -> 0x80.
    set_update(1'b1, 32'h100, 1'b1, 32'h80, 1'b0);
    step();
    step();
    set_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("lit trained pred_taken", 32'(pt[1]), 32'h1);
    chk("lit trained pred_target", ptg[1], 32'h80);
    chk("lit trained stat_branches", sb[1], 32'h2);
    step();

    // Counter 3 -> 2 still taken.
    set_update(1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    step();
    set_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("lit ctr2 pred_taken", 32'(pt[1]), 32'h1);
    step();

    // Three more not-taken: 2 -> 1 -> 0 -> 0 (saturated).
    set_update(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    repeat (3) step();
    set_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("lit ctr0 pred_taken", 32'(pt[1]), 32'h0);
    chk("lit ctr0 pred_target", ptg[1], 32'h0);
    step();

    // One taken from a saturated 0 gives 1: still not taken.
    set_update(1'b1, 32'h100, 1'b1, 32'h80, 1'b0);
    step();
    set_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("lit ctr1 pred_taken", 32'(pt[1]), 32'h0);
    step();
    set_update(1'b1, 32'h100, 1'b1, 32'h80, 1'b0);
    step();
    set_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("lit btb hit pred_target", ptg[1], 32'h80);
    step();

    // Alias 0x100 + 2*E: same index, different tag -> miss.
    lookup_pc = 32'h100 + 2 * E;
    @(negedge clk);
    chk("lit alias pred_taken", 32'(pt[1]), 32'h0);
    chk("lit alias pred_target", ptg[1], 32'h0);
    step();

    // Same-cycle lookup and update: old view now, new view next cycle.
    lookup_pc = 32'h104;
    set_update(1'b1, 32'h104, 1'b1, 32'h200, 1'b0);
    @(negedge clk);
    chk("lit bypass old pred_taken", 32'(pt[1]), 32'h0);
    step();
    set_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("lit bypass new pred_taken", 32'(pt[1]), 32'h1);
    chk("lit bypass new pred_target", ptg[1], 32'h200);
    step();

    // Stats preloaded to all-ones stay saturated under mispredicted updates.
    set_update(1'b1, 32'h10C, 1'b0, 32'h0, 1'b1);
    force dut0.stat_br_q = 32'hFFFF_FFFF;
    force dut0.stat_mp_q = 32'hFFFF_FFFF;
    force dut1.stat_br_q = 32'hFFFF_FFFF;
    force dut1.stat_mp_q = 32'hFFFF_FFFF;
    force dut2.stat_br_q = 32'hFFFF_FFFF;
    force dut2.stat_mp_q = 32'hFFFF_FFFF;
    for (int m = 0; m < 3; m++) begin
      m_sb[m] = 32'hFFFF_FFFF;
      m_sm[m] = 32'hFFFF_FFFF;
    end
    step();
    release dut0.stat_br_q;
    release dut0.stat_mp_q;
    release dut1.stat_br_q;
    release dut1.stat_mp_q;
    release dut2.stat_br_q;
    release dut2.stat_mp_q;
    step();
    set_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("lit sat stat_branches", sb[1], 32'hFFFF_FFFF);
    chk("lit sat stat_mispredicts", sm[1], 32'hFFFF_FFFF);
    step();

    // Clear beats a concurrent mispredicted update.
    stat_clr = 1'b1;
    set_update(1'b1, 32'h10C, 1'b1, 32'h300, 1'b1);
    step();
    stat_clr = 1'b0;
    set_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("lit clr stat_branches", sb[1], 32'h0);
    chk("lit clr stat_mispredicts", sm[1], 32'h0);
    chk("lit clr mode0 stat_branches", sb[0], 32'h0);
    step();

    // Randomised traffic over a small PC pool so hits and aliases are common.
    for (int n = 0; n < 3000; n++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
      stat_clr     = ($urandom_range(0, 199) == 0);
      lookup_valid = ($urandom_range(0, 3) != 0);
      lookup_pc    = ($urandom_range(0, 15) == 0) ? ($urandom & 32'hFFFF_FFFE)
                                                  : 32'h100 + 2 * $urandom_range(0, 63);
      update_valid      = ($urandom_range(0, 9) < 7);
      update_is_branch  = ($urandom_range(0, 9) < 8);
      update_pc         = ($urandom_range(0, 15) == 0) ? ($urandom & 32'hFFFF_FFFE)
                                                       : 32'h100 + 2 * $urandom_range(0, 63);
      update_taken      = $urandom_range(0, 1) == 1;
      update_target     = $urandom & 32'hFFFF_FFFE;
      update_mispredict = ($urandom_range(0, 9) < 3);
      step();
    end
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
